// File: rtl/ternary_ripple_carry_adder.sv
// ============================================================================
// Module   : ternary_ripple_carry_adder
// Brief    : Balanced-ternary ripple-carry adder with an optional operation
//            counter, compiled in when TERNARY_ADDER_OP_COUNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ternary_ripple_carry_adder #(
    parameter int WORD_SIZE   = 9,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                     clock,
    input  logic                     reset_enable,
    input  logic [2*WORD_SIZE-1:0]   input1,
    input  logic [2*WORD_SIZE-1:0]   input2,
    input  logic                     enable,
    output logic [2*WORD_SIZE-1:0]   result,
    output logic [1:0]               carry_out,
    output logic [COUNT_WIDTH-1:0]   op_count
);

    localparam logic [1:0] C_TRIT_NEG  = 2'b00;
    localparam logic [1:0] C_TRIT_ZERO = 2'b01;
    localparam logic [1:0] C_TRIT_POS  = 2'b10;

    // Code 2'b11 is not a legal trit; treating it as zero keeps outputs clean.
    function automatic logic signed [2:0] decode_trit(input logic [1:0] code);
        logic signed [2:0] v;
        case (code)
            C_TRIT_NEG: v = -3'sd1;
            C_TRIT_POS: v = 3'sd1;
            default:    v = 3'sd0;
        endcase
        return v;
    endfunction

    function automatic logic [1:0] encode_trit(input logic signed [2:0] v);
        logic [1:0] code;
        if (v < 3'sd0)
            code = C_TRIT_NEG;
        else if (v > 3'sd0)
            code = C_TRIT_POS;
        else
            code = C_TRIT_ZERO;
        return code;
    endfunction

    logic signed [2:0] w_carry [WORD_SIZE+1];

    assign w_carry[0] = 3'sd0;

    generate
        for (genvar i = 0; i < WORD_SIZE; i++) begin : g_stage
            logic signed [2:0] w_a;
            logic signed [2:0] w_b;
            logic signed [2:0] w_t;
            logic signed [2:0] w_c;
            logic signed [2:0] w_s;

            assign w_a = decode_trit(input1[2*i +: 2]);
            assign w_b = decode_trit(input2[2*i +: 2]);
            assign w_t = w_a + w_b + w_carry[i];
            assign w_c = (w_t >= 3'sd2)  ? 3'sd1  :
                         (w_t <= -3'sd2) ? -3'sd1 : 3'sd0;
            // Stage sum always lands in -1..+1, so 3-bit wraparound is harmless.
            assign w_s = w_t - (w_c + w_c + w_c);

            assign w_carry[i+1]     = w_c;
            assign result[2*i +: 2] = encode_trit(w_s);
        end
    endgenerate

    assign carry_out = encode_trit(w_carry[WORD_SIZE]);

`ifdef TERNARY_ADDER_OP_COUNT_EN
    logic [COUNT_WIDTH-1:0] r_op_count = '0;

    always_ff @(posedge clock) begin
        if (reset_enable)
            r_op_count <= '0;
        else if (enable)
            r_op_count <= r_op_count + COUNT_WIDTH'(1);
    end

    assign op_count = r_op_count;
`else
    logic w_unused_ctrl;

    assign w_unused_ctrl = ^{clock, reset_enable, enable};
    assign op_count      = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ternary_ripple_carry_adder.sv
// ============================================================================
// Module   : tb_ternary_ripple_carry_adder
// Brief    : Scoreboard bench for the balanced-ternary adder and its counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ternary_ripple_carry_adder;

    localparam int C_W  = 9;
    localparam int C_CW = 32;
    localparam int C_MAX = 9841;

    logic                  clock = 1'b0;
    logic                  reset_enable;
    logic [2*C_W-1:0]      input1;
    logic [2*C_W-1:0]      input2;
    logic                  enable;
    logic [2*C_W-1:0]      result;
    logic [1:0]            carry_out;
    logic [C_CW-1:0]       op_count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string            tag;
        logic [2*C_W-1:0] res;
        logic [1:0]       cy;
    } exp_t;

    exp_t sb[$];

    ternary_ripple_carry_adder #(
        .WORD_SIZE   (C_W),
        .COUNT_WIDTH (C_CW)
    ) dut (
        .clock        (clock),
        .reset_enable (reset_enable),
        .input1       (input1),
        .input2       (input2),
        .enable       (enable),
        .result       (result),
        .carry_out    (carry_out),
        .op_count     (op_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int trit_val(input logic [1:0] code);
        if (code == 2'b00) return -1;
        if (code == 2'b10) return 1;
        return 0;
    endfunction

    function automatic int vec_val(input logic [2*C_W-1:0] v);
        int acc = 0;
        for (int i = C_W - 1; i >= 0; i--)
            acc = acc * 3 + trit_val(v[2*i +: 2]);
        return acc;
    endfunction

    // Balanced-ternary digits of v, C_W+1 trits, LSB first.
    function automatic logic [2*C_W+1:0] to_trits(input int v);
        logic [2*C_W+1:0] out;
        int               x;
        int               r;
        x   = v;
        out = '0;
        for (int i = 0; i <= C_W; i++) begin
            r = ((x % 3) + 3) % 3;
            if (r == 2) begin
                out[2*i +: 2] = 2'b00;
                x = (x + 1) / 3;
            end else begin
                out[2*i +: 2] = (r == 1) ? 2'b10 : 2'b01;
                x = (x - r) / 3;
            end
        end
        return out;
    endfunction

    function automatic logic [2*C_W-1:0] enc(input int v);
        logic [2*C_W+1:0] t;
        t = to_trits(v);
        return t[2*C_W-1:0];
    endfunction

    function automatic int count_11(input logic [2*C_W+1:0] v);
        int n = 0;
        for (int i = 0; i <= C_W; i++)
            if (v[2*i +: 2] == 2'b11) n++;
        return n;
    endfunction

    task automatic apply(input string tag, input logic [2*C_W-1:0] a, input logic [2*C_W-1:0] b);
        exp_t             e;
        logic [2*C_W+1:0] t;
        input1 = a;
        input2 = b;
        t      = to_trits(vec_val(a) + vec_val(b));
        e.tag  = tag;
        e.res  = t[2*C_W-1:0];
        e.cy   = t[2*C_W+1:2*C_W];
        sb.push_back(e);
        #1;
        e = sb.pop_front();
        check({e.tag, ".result"}, 64'(result), 64'(e.res));
        check({e.tag, ".carry"}, 64'(carry_out), 64'(e.cy));
        check({e.tag, ".no11"}, 64'(count_11({carry_out, result})), 64'd0);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [2*C_W-1:0] res_a;
        logic [1:0]       cy_a;
        logic [2*C_W-1:0] ra;
        logic [2*C_W-1:0] rb;
        logic [31:0]      rnd;

        reset_enable = 1'b1;
        enable       = 1'b0;
        input1       = '0;
        input2       = '0;
        tick();
        check("reset.op_count", 64'(op_count), 64'd0);
        reset_enable = 1'b0;

        apply("p5_p7", enc(5), enc(7));
        check("p5_p7.value", 64'(vec_val(result)), 64'd12);
        check("p5_p7.carry_zero", 64'(carry_out), 64'(2'b01));

        apply("max_p1", enc(C_MAX), enc(1));
        check("max_p1.all_neg", 64'(result), 64'd0);
        check("max_p1.carry_pos", 64'(carry_out), 64'(2'b10));

        apply("min_m1", enc(-C_MAX), enc(-1));
        check("min_m1.all_pos", 64'(result), 64'h2AAAA);
        check("min_m1.carry_neg", 64'(carry_out), 64'(2'b00));

        apply("m3_p3", enc(-3), enc(3));
        check("m3_p3.all_zero", 64'(result), 64'h15555);
        res_a = result;
        cy_a  = carry_out;
        apply("p3_m3", enc(3), enc(-3));
        check("swap.result", 64'(result), 64'(res_a));
        check("swap.carry", 64'(carry_out), 64'(cy_a));

        apply("code11_p4", 18'h3FFFF, enc(4));
        check("code11_p4.value", 64'(vec_val(result)), 64'd4);

        reset_enable = 1'b1;
        apply("under_reset", enc(100), enc(-37));
        reset_enable = 1'b0;

        for (int i = 0; i < 30; i++) begin
            rnd = $urandom();
            ra  = rnd[2*C_W-1:0];
            rnd = $urandom();
            rb  = rnd[2*C_W-1:0];
            apply("rand_raw", ra, rb);
            apply("rand_raw_swap", rb, ra);
        end
        for (int i = 0; i < 30; i++)
            apply("rand_val", enc($urandom_range(0, 2*C_MAX) - C_MAX),
                              enc($urandom_range(0, 2*C_MAX) - C_MAX));

`ifdef TERNARY_ADDER_OP_COUNT_EN
        reset_enable = 1'b1;
        tick();
        reset_enable = 1'b0;
        check("cnt.after_reset", 64'(op_count), 64'd0);
        enable = 1'b1;
        repeat (5) tick();
        check("cnt.after_5", 64'(op_count), 64'd5);
        enable = 1'b0;
        repeat (3) tick();
        check("cnt.hold_3", 64'(op_count), 64'd5);
        enable       = 1'b1;
        reset_enable = 1'b1;
        tick();
        check("cnt.reset_wins", 64'(op_count), 64'd0);
        reset_enable = 1'b0;
        tick();
        check("cnt.resume", 64'(op_count), 64'd1);
        enable = 1'b0;
`else
        enable = 1'b1;
        repeat (10) tick();
        check("cnt.disabled", 64'(op_count), 64'd0);
        enable = 1'b0;
`endif
        apply("final_p5_p7", enc(5), enc(7));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
